config_loader: RTL and testbench
================================

Name: config_loader

Overview:
- Upstream feeder of the fabric configuration bus. Drives `config_addr` and `config_data` into every tile.
- Accepts a word-serial bitstream over a valid/ready handshake: a header (write count N), then N pairs of address word and data word.
- Replays each pair on the config bus as a held write. Tiles self-select on `config_addr[15:0] == tile_id` and sub-unit code `config_addr[31:16]`.
- Between writes, the bus rests at an address that no sub-unit decodes.

Parameters:
- COUNT_W, 16: width of the header write count and of the `writes_done` counter.
- HOLD_CYCLES, 1: cycles each write is held on the bus. Legal range 1..15.

Ports:
- clk  in  1  fabric clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on posedge clk.
- in_data  in  32  bitstream word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- config_addr  out  32  {sub-unit code[31:16], tile id[15:0]}.
- config_data  out  32  configuration payload.
- busy  out  1  a load is in progress (any state except IDLE/DONE).
- done  out  1  sticky; last write of the load has completed.
- err  out  1  sticky; checksum mismatch (only with the optional feature, else tied 0).
- writes_done  out  COUNT_W  writes issued since the last header.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE; config_addr=0, config_data=0, in_ready=0, busy=0, done=0, err=0, writes_done=0.
  - Applies mid-load too: the load is abandoned and the bus returns to 0 the next cycle.
  - Any partial tile writes are not undone.
- Idle bus value: config_addr=32'h0 whenever not in WRITE. Sub-unit code 0 is never decoded by any tile, so no tile is written.
- Transfer rule: a word moves only when in_valid && in_ready at a posedge. in_data may change freely when in_valid==0.
- in_ready: 1 in IDLE, DONE, ADDR, DATA and CSUM; 0 in WRITE.
- FSM states: IDLE, ADDR, DATA, WRITE, CSUM (feature only), DONE.
- IDLE/DONE, header accepted:
  - remaining = in_data[COUNT_W-1:0]; upper bits are ignored.
  - writes_done=0, done=0, err=0.
  - Go to ADDR if the count is nonzero. If the count is 0, go to CSUM when the feature is enabled, otherwise DONE with done=1.
- ADDR, word accepted: latch it into an address holding register; go to DATA.
- DATA, word accepted:
  - latch it into a data holding register; go to WRITE.
  - Latency: data accepted at edge t puts config_addr/config_data on the bus from cycle t+1 through t+HOLD_CYCLES.
- WRITE:
  - The bus shows the held pair for exactly HOLD_CYCLES cycles, counted by a hold counter.
  - On the final hold cycle: writes_done += 1 and remaining -= 1. Next state is ADDR if remaining was >1, otherwise CSUM (feature) or DONE with done=1.
  - The bus drops to 0 in the cycle after WRITE.
- Back-to-back loads: with in_valid held high, the pair cadence is 2+HOLD_CYCLES cycles.
- DONE: done stays 1 until the next header is accepted. A header word accepted in DONE is treated exactly as in IDLE.
- No timeout: an in_valid stall leaves the loader waiting in its current state indefinitely, with the bus idle.
- Count wrap: a header of 2^COUNT_W-1 is legal. writes_done saturates at all-ones.

Optional Feature:
- Macro: CONFIG_LOADER_CHECKSUM_EN.
- Enabled:
  - A 32-bit accumulator XORs the header and every accepted address and data word.
  - After the last write (or straight after a zero-count header), state CSUM accepts one trailing word.
  - If that word != accumulator: err=1, sticky until the next header. Writes are already applied regardless.
  - Then go to DONE with done=1.
- Disabled: no CSUM state and no accumulator; err is constant 0.

Decomposition:
- Package fabric_cfg_pkg holds:
  - the loader state enum;
  - sub-unit codes CB0=16'd4, CB1=16'd5, SB=16'd6, CLB=16'd7;
  - CFG_IDLE_ADDR=32'h0.
- No sub-module; the accumulator and hold counter are inline. Single module.

Test Plan:
- Reset mid-WRITE: rst=0 for 1 cycle while the bus shows 32'h0006_0003 → next cycle config_addr=0, busy=0, state IDLE, writes_done=0.
- Single write, HOLD_CYCLES=1: stream 1, 32'h0004_0002, 32'hDEAD_BEEF with in_valid continuous → bus = {0004_0002, DEADBEEF} for exactly 1 cycle, one cycle after the data handshake; done=1; writes_done=1.
- Three writes, HOLD_CYCLES=3, in_valid toggled 1010: addresses 0005_0001, 0006_0001, 0007_0001 → each held 3 cycles; in_ready=0 throughout WRITE; the bus is 0 in every gap; writes_done=3.
- Zero-count header 0 → done=1 next cycle, no bus activity (feature off); with the feature on, done=1 only after the trailing word 32'h0 is accepted.
- Checksum (feature on): stream 1, A=32'h0004_0001, D=32'h0000_00FF, then 1^A^D → err=0. Same stream with a wrong trailing word → err=1, done=1, and the write still appeared on the bus.
- Back-to-back loads: a second header arrives while in DONE → done clears the same edge, writes_done resets to 0, and the new load proceeds normally.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration bus.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fabric_cfg_pkg;

    // Loader sequencing states; CSUM is only entered when the checksum feature is built in
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5
    } cfg_state_t;

    // Sub-unit codes carried in config_addr[31:16]; code 0 is never decoded by a tile
    localparam logic [15:0] CB0 = 16'd4;
    localparam logic [15:0] CB1 = 16'd5;
    localparam logic [15:0] SB  = 16'd6;
    localparam logic [15:0] CLB = 16'd7;

    // Resting bus address between writes
    localparam logic [31:0] CFG_IDLE_ADDR = 32'h0;

    // Build a bus address from a sub-unit code and a tile id
    function automatic logic [31:0] cfg_addr(input logic [15:0] sub, input logic [15:0] tile);
        return {sub, tile};
    endfunction

endpackage

// File: rtl/config_loader.sv
// Replays a word-serial bitstream (header N, then N addr/data pairs) as held writes on the config bus.
// Latency: data word accepted at edge t is on the bus for cycles t+1..t+HOLD_CYCLES; pair cadence 2+HOLD_CYCLES.
// Backpressure: in_ready low only while a write is held; an in_valid stall just waits with the bus idle.
// Optional trailing-checksum check is built in with `define CONFIG_LOADER_CHECKSUM_EN.
module config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int COUNT_W     = 16,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [31:0]        config_addr,
    output logic [31:0]        config_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [COUNT_W-1:0] writes_done
);

    localparam logic [3:0]         HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    cfg_state_t         r_state;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] r_writes_done;
    logic [31:0]        r_addr;
    logic [31:0]        r_cfg_addr;
    logic [31:0]        r_cfg_data;
    logic [3:0]         r_hold;
    logic               r_done;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    logic [31:0]        r_acc;
    logic               r_err;
`endif

    logic               w_in_ready;
    logic               w_hs;
    logic [COUNT_W-1:0] w_hdr_cnt;

    // Ready is held low while reset is applied so nothing is taken during reset
    assign w_in_ready = rst && (r_state != ST_WRITE);
    assign w_hs       = in_valid && w_in_ready;
    assign w_hdr_cnt  = in_data[COUNT_W-1:0];

    // Loader FSM: header/addr/data capture, held write replay, optional checksum compare
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_writes_done <= '0;
            r_addr        <= '0;
            r_cfg_addr    <= CFG_IDLE_ADDR;
            r_cfg_data    <= '0;
            r_hold        <= '0;
            r_done        <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
            r_acc         <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_hs) begin
                        r_remaining   <= w_hdr_cnt;
                        r_writes_done <= '0;
                        r_done        <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        r_acc         <= in_data;
                        r_err         <= 1'b0;
`endif
                        if (w_hdr_cnt != '0) begin
                            r_state <= ST_ADDR;
                        end else begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_hs) begin
                        r_addr  <= in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        r_acc   <= r_acc ^ in_data;
`endif
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        // Pair goes straight onto the bus registers so it appears next cycle
                        r_cfg_addr <= r_addr;
                        r_cfg_data <= in_data;
`ifdef CONFIG_LOADER_CHECKSUM_EN
                        r_acc      <= r_acc ^ in_data;
`endif
                        r_hold     <= '0;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (r_hold == HOLD_LAST) begin
                        r_cfg_addr  <= CFG_IDLE_ADDR;
                        r_cfg_data  <= '0;
                        r_remaining <= r_remaining - CNT_ONE;
                        if (r_writes_done != '1) begin
                            r_writes_done <= r_writes_done + CNT_ONE;
                        end
                        if (r_remaining > CNT_ONE) begin
                            r_state <= ST_ADDR;
                        end else begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
`endif
                        end
                    end else begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                ST_CSUM: begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
                    if (w_hs) begin
                        r_err   <= (in_data != r_acc);
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign config_addr = r_cfg_addr;
    assign config_data = r_cfg_data;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done        = r_done;
    assign writes_done = r_writes_done;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    assign err         = r_err;
`else
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (HOLD_CYCLES 1 and 3) driven with scripted and random loads.
// Expected bus writes come from the stream itself; a negedge monitor collects observed bus runs.
// Works with or without CONFIG_LOADER_CHECKSUM_EN defined.
`timescale 1ns/1ps
module tb_config_loader;
    import fabric_cfg_pkg::*;

    localparam int CW = 16;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] d;
        int          len;
        int          start;
        bit          nogap;
        bit          rdybad;
    } run_t;

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] d;
        int          start;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   t_data  [2];
    logic          t_valid [2];
    logic          t_ready [2];
    logic [31:0]   t_addr  [2];
    logic [31:0]   t_cdata [2];
    logic          t_busy  [2];
    logic          t_done  [2];
    logic          t_err   [2];
    logic [CW-1:0] t_wd    [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    run_t obs_q[$];
    exp_t exp_q[$];
    logic [31:0] la[32];
    logic [31:0] ld[32];

    config_loader #(.COUNT_W(CW), .HOLD_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .in_data(t_data[0]), .in_valid(t_valid[0]), .in_ready(t_ready[0]),
        .config_addr(t_addr[0]), .config_data(t_cdata[0]), .busy(t_busy[0]), .done(t_done[0]),
        .err(t_err[0]), .writes_done(t_wd[0])
    );

    config_loader #(.COUNT_W(CW), .HOLD_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .in_data(t_data[1]), .in_valid(t_valid[1]), .in_ready(t_ready[1]),
        .config_addr(t_addr[1]), .config_data(t_cdata[1]), .busy(t_busy[1]), .done(t_done[1]),
        .err(t_err[1]), .writes_done(t_wd[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int hold_of(input int idx);
        return (idx == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [15:0] c;
        case ($urandom_range(0, 3))
            0:       c = CB0;
            1:       c = CB1;
            2:       c = SB;
            default: c = CLB;
        endcase
        return cfg_addr(c, 16'($urandom));
    endfunction

    // Bus monitor: groups consecutive identical nonzero bus values into runs
    logic [31:0] m_pa[2];
    logic [31:0] m_pd[2];
    int          m_len[2];
    int          m_start[2];
    bit          m_rb[2];
    run_t        m_r;
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_len[i] = 0; m_start[i] = 0; m_rb[i] = 0; m_pa[i] = '0; m_pd[i] = '0;
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_len[i] > 0 && (t_addr[i] == 32'h0 || t_addr[i] != m_pa[i] || t_cdata[i] != m_pd[i])) begin
                m_r.idx = i; m_r.a = m_pa[i]; m_r.d = m_pd[i]; m_r.len = m_len[i];
                m_r.start = m_start[i]; m_r.nogap = (t_addr[i] != 32'h0); m_r.rdybad = m_rb[i];
                obs_q.push_back(m_r);
                m_len[i] = 0;
            end
            if (t_addr[i] != 32'h0) begin
                if (m_len[i] == 0) begin
                    m_start[i] = cyc;
                    m_rb[i]    = 1'b0;
                end
                m_len[i] = m_len[i] + 1;
                if (t_ready[i]) m_rb[i] = 1'b1;
                m_pa[i] = t_addr[i];
                m_pd[i] = t_cdata[i];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Present one word, optionally after idle cycles; returns the handshake edge number
    task automatic send_word(input int idx, input logic [31:0] w, input int gap,
                             output int edge_no, output bit ok);
        bit rdy;
        ok = 1'b0;
        edge_no = 0;
        for (int g = 0; g < gap; g++) begin
            t_valid[idx] = 1'b0;
            t_data[idx]  = $urandom;
            @(posedge clk); #1;
        end
        t_valid[idx] = 1'b1;
        t_data[idx]  = w;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            rdy = t_ready[idx];
            @(posedge clk);
            edge_no = cyc;
            #1;
            if (rdy) ok = 1'b1;
        end
    endtask

    function automatic int gap_of(input int gmode);
        if (gmode == 1) return 1;
        if (gmode == 2) return $urandom_range(0, 2);
        return 0;
    endfunction

    // Full load: header (count n plus hdr_hi in upper bits), pairs la/ld, optional trailer
    task automatic run_load(input string name, input int idx, input int n, input logic [15:0] hdr_hi,
                            input logic [31:0] tr_xor, input int gmode);
        logic [31:0] hdr, acc;
        int e, h, waited;
        bit ok, all_ok, fin;
        logic exp_err, exp_hdr_done;
        exp_t x;
        run_t r;
        h   = hold_of(idx);
        hdr = {hdr_hi, 16'(n)};
        acc = hdr;
        for (int k = 0; k < n; k++) acc = acc ^ la[k] ^ ld[k];
        exp_err      = CSUM_ON && (tr_xor != 32'h0);
        exp_hdr_done = (n == 0) && !CSUM_ON;
        obs_q.delete();
        exp_q.delete();
        all_ok = 1'b1;

        send_word(idx, hdr, gap_of(gmode), e, ok);
        all_ok &= ok;
        total++;
        if (t_done[idx] !== exp_hdr_done || t_wd[idx] !== '0) begin
            bad++;
            $display("FAIL %s header_edge: done=%0b writes_done=%0d, want done=%0b writes_done=0",
                     name, t_done[idx], t_wd[idx], exp_hdr_done);
        end

        for (int k = 0; k < n; k++) begin
            send_word(idx, la[k], gap_of(gmode), e, ok);
            all_ok &= ok;
            send_word(idx, ld[k], gap_of(gmode), e, ok);
            all_ok &= ok;
            x.idx = idx; x.a = la[k]; x.d = ld[k]; x.start = e + 1;
            exp_q.push_back(x);
        end
`ifdef CONFIG_LOADER_CHECKSUM_EN
        send_word(idx, acc ^ tr_xor, gap_of(gmode), e, ok);
        all_ok &= ok;
`endif
        t_valid[idx] = 1'b0;

        fin = 1'b0;
        waited = 0;
        while (!fin && waited < 200) begin
            @(negedge clk);
            waited++;
            if (t_done[idx] && !t_busy[idx]) fin = 1'b1;
        end
        @(posedge clk); #1;

        total++;
        if (!all_ok || !fin) begin
            bad++;
            $display("FAIL %s progress: handshakes_ok=%0b reached_done=%0b, want 1 and 1", name, all_ok, fin);
        end
        total++;
        if (obs_q.size() != n) begin
            bad++;
            $display("FAIL %s write_count_on_bus: got %0d bus writes, want %0d", name, obs_q.size(), n);
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            r = obs_q[k];
            x = exp_q[k];
            total++;
            if (r.idx != x.idx || r.a !== x.a || r.d !== x.d || r.len != h || r.start != x.start
                || r.nogap || r.rdybad) begin
                bad++;
                $display("FAIL %s write%0d: got inst=%0d addr=%h data=%h len=%0d start=%0d nogap=%0b ready_in_write=%0b, want inst=%0d addr=%h data=%h len=%0d start=%0d nogap=0 ready_in_write=0",
                         name, k, r.idx, r.a, r.d, r.len, r.start, r.nogap, r.rdybad,
                         x.idx, x.a, x.d, h, x.start);
            end
        end
        total++;
        if (t_wd[idx] !== CW'(n) || t_done[idx] !== 1'b1 || t_busy[idx] !== 1'b0
            || t_err[idx] !== exp_err || t_addr[idx] !== 32'h0 || t_ready[idx] !== 1'b1) begin
            bad++;
            $display("FAIL %s end_state: writes_done=%0d done=%0b busy=%0b err=%0b addr=%h ready=%0b, want %0d 1 0 %0b 00000000 1",
                     name, t_wd[idx], t_done[idx], t_busy[idx], t_err[idx], t_addr[idx], t_ready[idx],
                     n, exp_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t_valid[i] = 1'b0;
            t_data[i]  = $urandom;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (t_addr[i] !== 32'h0 || t_cdata[i] !== 32'h0) begin
                bad++; $display("FAIL reset_bus inst%0d: addr=%h data=%h, want 0 0", i, t_addr[i], t_cdata[i]);
            end
            total++;
            if (t_ready[i] !== 1'b0 || t_busy[i] !== 1'b0) begin
                bad++; $display("FAIL reset_ready_busy inst%0d: ready=%0b busy=%0b, want 0 0", i, t_ready[i], t_busy[i]);
            end
            total++;
            if (t_done[i] !== 1'b0 || t_err[i] !== 1'b0 || t_wd[i] !== '0) begin
                bad++; $display("FAIL reset_status inst%0d: done=%0b err=%0b writes_done=%0d, want 0 0 0",
                                i, t_done[i], t_err[i], t_wd[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (t_ready[i] !== 1'b1 || t_busy[i] !== 1'b0) begin
                bad++; $display("FAIL idle_after_reset inst%0d: ready=%0b busy=%0b, want 1 0", i, t_ready[i], t_busy[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        la[0] = 32'h0004_0002;
        ld[0] = 32'hDEAD_BEEF;
        run_load("single_write", 0, 1, 16'h0, 32'h0, 0);
    endtask

    task automatic test_three_writes();
        la[0] = 32'h0005_0001; la[1] = 32'h0006_0001; la[2] = 32'h0007_0001;
        for (int k = 0; k < 3; k++) ld[k] = $urandom;
        run_load("three_writes_toggled", 1, 3, 16'h0, 32'h0, 1);
    endtask

    task automatic test_zero_count();
        run_load("zero_count_h1", 0, 0, 16'h0, 32'h0, 0);
        run_load("zero_count_h3", 1, 0, 16'h0, 32'h0, 1);
    endtask

    task automatic test_checksum();
        la[0] = 32'h0004_0001;
        ld[0] = 32'h0000_00FF;
        run_load("checksum_good", 0, 1, 16'h0, 32'h0, 0);
        run_load("checksum_bad", 0, 1, 16'h0, 32'h0000_0001, 0);
        run_load("checksum_good_again", 0, 1, 16'h0, 32'h0, 1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin la[k] = rand_addr(); ld[k] = $urandom; end
        run_load("back_to_back_a", 1, 2, 16'hABCD, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin la[k] = rand_addr(); ld[k] = $urandom; end
        run_load("back_to_back_b", 1, 3, 16'hFFFF, 32'h0, 0);
    endtask

    task automatic test_reset_mid_write();
        int e, waited;
        bit ok, seen;
        send_word(1, 32'h2, 0, e, ok);
        send_word(1, 32'h0005_0003, 0, e, ok);
        send_word(1, 32'h1111_2222, 0, e, ok);
        send_word(1, 32'h0006_0003, 0, e, ok);
        send_word(1, 32'h3333_4444, 0, e, ok);
        t_valid[1] = 1'b0;
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < 50) begin
            @(negedge clk);
            waited++;
            if (t_addr[1] == 32'h0006_0003) seen = 1'b1;
        end
        total++;
        if (!seen || t_wd[1] !== CW'(1) || t_busy[1] !== 1'b1) begin
            bad++; $display("FAIL mid_write_setup: seen=%0b writes_done=%0d busy=%0b, want 1 1 1", seen, t_wd[1], t_busy[1]);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (t_addr[1] !== 32'h0 || t_busy[1] !== 1'b0 || t_wd[1] !== '0 || t_done[1] !== 1'b0
            || t_ready[1] !== 1'b1) begin
            bad++; $display("FAIL reset_mid_write: addr=%h busy=%0b writes_done=%0d done=%0b ready=%0b, want 00000000 0 0 0 1",
                            t_addr[1], t_busy[1], t_wd[1], t_done[1], t_ready[1]);
        end
        @(posedge clk); #1;
        obs_q.delete();
    endtask

    task automatic test_random();
        int idx, n;
        logic [31:0] tx;
        for (int t = 0; t < 8; t++) begin
            idx = $urandom_range(0, 1);
            n   = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) begin la[k] = rand_addr(); ld[k] = $urandom; end
            tx = ($urandom_range(0, 1) == 1) ? 32'($urandom) | 32'h1 : 32'h0;
            run_load("random_load", idx, n, 16'($urandom), tx, 2);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_three_writes();
        test_zero_count();
        test_checksum();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
